pool_window_ctrl: RTL
=====================

POOL_WINDOW_CTRL -- requirements
Module: pool_window_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, sample and result width in bits.
REQ-002 Parameter IMG_W, default 8, feature-map columns; even, >=2.
REQ-003 Parameter IMG_H, default 8, feature-map rows; even, >=2.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle frame start; ignored unless idle.
REQ-007 in_valid  input  1  input sample valid.
REQ-008 in_data  input  DATA_W  input sample, raster order (row-major).
REQ-009 in_ready  output  1  controller accepts sample this cycle.
REQ-010 out_valid  output  1  pooled result valid.
REQ-011 out_data  output  DATA_W  pooled 2x2 maximum.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse, frame complete.

Function
REQ-015 FSM states IDLE, RUN, FLUSH; IDLE->RUN on start, RUN->FLUSH on acceptance of sample (IMG_H-1, IMG_W-1), FLUSH->IDLE when the final result handshakes.
REQ-016 Input handshake: transfer when in_valid && in_ready; in_ready = (state==RUN) && !(out_valid && !out_ready).
REQ-017 Output handshake: transfer when out_valid && out_ready; out_valid/out_data held stable until transfer.
REQ-018 Column counter 0..IMG_W-1 and row counter 0..IMG_H-1 advance only on input transfer; column wraps to 0 with row increment.
REQ-019 Even column: sample latched as pair candidate; odd column: pair max = max(candidate, sample).
REQ-020 Even row: pair max written to line buffer entry col/2 (IMG_W/2 entries, DATA_W each).
REQ-021 Odd row: result = max(pair max, line buffer entry col/2); registered to out_data, out_valid set the cycle after the completing input transfer (latency 1).
REQ-022 Output count per frame exactly (IMG_W/2)*(IMG_H/2), in raster order of the pooled map.
REQ-023 Comparison unsigned by default; equal operands yield that value.
REQ-024 done pulses the cycle after the final output transfer; busy falls on the same cycle.
REQ-025 start while busy has no effect; in_valid while IDLE ignored (in_ready low).
REQ-026 Simultaneous output transfer and new completing input: out_data updated, out_valid stays high, no result lost.

Reset
REQ-027 rst_n low: state IDLE, counters 0, in_ready 0, out_valid 0, out_data 0, busy 0, done 0; line buffer contents undefined.
REQ-028 Reset mid-frame abandons the frame; no partial result emitted after release.

Configuration
REQ-029 Macro POOL_SIGNED_EN defined: all comparisons treat data as two's-complement signed; undefined: unsigned.

Structure
REQ-030 Shared package pool_pkg holds FSM state enumeration and DATA_W default constant.
REQ-031 One sub-module max2_cmp (two DATA_W inputs, max output, honours POOL_SIGNED_EN), instantiated for pair and vertical compares.

Verification
REQ-032 4x4 map values 0..15 raster, out_ready=1 -> outputs 5,7,13,15 then done pulse.
REQ-033 Same map, out_ready low 5 cycles after first result -> out_data holds 5, in_ready low, no loss; sequence 5,7,13,15.
REQ-034 All samples 16'h8000 except one 16'h0001 per window; unsigned -> 16'h8000; with POOL_SIGNED_EN -> 16'h0001.
REQ-035 start pulsed mid-frame -> ignored; output count remains 4.
REQ-036 rst_n low after 6 samples, then new start with 4x4 map -> exactly 4 correct results, no stale output.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool window controller.
// Build option: POOL_SIGNED_EN selects two's-complement comparison.
package pool_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/max2_cmp.sv
// Two-input maximum selector shared by the pair and vertical compares.
// Build option: POOL_SIGNED_EN makes the compare two's-complement signed.
module max2_cmp
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] max_v
);

`ifdef POOL_SIGNED_EN
  assign max_v = ($signed(a) >= $signed(b)) ? a : b;
`else
  assign max_v = (a >= b) ? a : b;
`endif

endmodule

// File: rtl/pool_window_ctrl.sv
// Streaming 2x2 max-pool: raster input, one line buffer of pair maxima, registered output.
// Build option: POOL_SIGNED_EN (signed compares inside max2_cmp).
module pool_window_ctrl
  import pool_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // Column is tracked as pair index plus odd/even phase so pcol addresses the line buffer directly.
  localparam int PW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int RW = $clog2(IMG_H);
  localparam logic [PW-1:0] PCOL_LAST = PW'(IMG_W / 2 - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  state_t            state, state_nxt;
  logic [PW-1:0]     pcol;
  logic              odd_col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;
  logic [DATA_W-1:0] line_buf [IMG_W/2];

  logic in_xfer, out_xfer, last_in, win_done;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_in  = in_xfer && odd_col && (pcol == PCOL_LAST) && (row == ROW_LAST);
  assign win_done = in_xfer && odd_col && row[0];

  max2_cmp #(.DATA_W(DATA_W)) u_pair_cmp (.a(cand),     .b(in_data),        .max_v(pair_max));
  max2_cmp #(.DATA_W(DATA_W)) u_vert_cmp (.a(pair_max), .b(line_buf[pcol]), .max_v(win_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start)    state_nxt = ST_RUN;
      ST_RUN:   if (last_in)  state_nxt = ST_FLUSH;
      ST_FLUSH: if (out_xfer) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  // Input is throttled only while a result is waiting on a stalled consumer.
  assign in_ready = (state == ST_RUN) && !(out_valid && !out_ready);
  assign busy     = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcol    <= '0;
      odd_col <= 1'b0;
      row     <= '0;
      cand    <= '0;
    end else if (state == ST_IDLE && start) begin
      pcol    <= '0;
      odd_col <= 1'b0;
      row     <= '0;
    end else if (in_xfer) begin
      odd_col <= ~odd_col;
      if (!odd_col) cand <= in_data;
      if (odd_col) begin
        if (pcol == PCOL_LAST) begin
          pcol <= '0;
          row  <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          pcol <= pcol + 1'b1;
        end
      end
    end
  end

  // NOTE: the line buffer has no reset; each entry is written on an even row before any odd-row read.
  always_ff @(posedge clk) begin
    if (in_xfer && odd_col && !row[0]) line_buf[pcol] <= pair_max;
  end

  // A completing window takes priority, so a same-cycle drain and refill keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      if (win_done) begin
        out_valid <= 1'b1;
        out_data  <= win_max;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      done <= (state == ST_FLUSH) && out_xfer;
    end
  end

endmodule
